// File: rtl/arm_mul_iter_if.sv
// ---------------------------------------------------------------------------
// arm_mul_iter_if
// Request/response bundle between the execute stage and the iterative
// multiplier.
//   start            request strobe, only honoured while the unit is idle
//   op[2:0]          [0]=accumulate, [1]=long, [2]=signed (long ops only)
//   a, b             multiplicand (Rm) and multiplier (Rs)
//   acc_hi, acc_lo   accumulate value (acc_hi used by long accumulate only)
//   c_in, v_in       current C/V flags, passed through to out_c/out_v
//   busy, done       unit occupied / one-cycle result strobe
//   res_lo, res_hi   result words; wrd_hi marks a long result
//   out_n..out_v     flag results
// master: the requesting pipeline stage. slave: the multiplier.
// ---------------------------------------------------------------------------
interface arm_mul_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             c_in;
  logic             v_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             wrd_hi;
  logic             out_n;
  logic             out_z;
  logic             out_c;
  logic             out_v;

  modport master (
    output start, op, a, b, acc_hi, acc_lo, c_in, v_in,
    input  busy, done, res_lo, res_hi, wrd_hi, out_n, out_z, out_c, out_v
  );

  modport slave (
    input  start, op, a, b, acc_hi, acc_lo, c_in, v_in,
    output busy, done, res_lo, res_hi, wrd_hi, out_n, out_z, out_c, out_v
  );
endinterface

// File: rtl/arm_mul_iter.sv
// ---------------------------------------------------------------------------
// arm_mul_iter
// Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit for the ARM execute stage.
// Retires RADIX_BITS multiplier bits per CALC cycle, LSB first, with optional
// early termination once the remaining multiplier bits carry no information.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset; aborts any operation in flight
//   mul_if  slave side of arm_mul_iter_if (start/op/operands in, results out)
// Parameters:
//   WIDTH       operand width (long results are 2*WIDTH)
//   RADIX_BITS  multiplier bits per cycle, one of 1/2/4/8 dividing WIDTH
//   EARLY_TERM  1 = stop as soon as the remaining multiplier bits are
//               all copies of the fill bit, 0 = always WIDTH/RADIX_BITS cycles
// ---------------------------------------------------------------------------
module arm_mul_iter #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int EARLY_TERM = 1
) (
  input logic          clk,
  input logic          rst_n,
  arm_mul_iter_if.slave mul_if
);

  localparam int ITER = WIDTH / RADIX_BITS;
  localparam int CW   = $clog2(ITER + 1);
  localparam int W2   = 2 * WIDTH;

  // Elaboration-time guard: an unsupported radix instantiates a module that
  // does not exist, so the build stops instead of producing a wrong multiplier.
  if (!((RADIX_BITS == 1) || (RADIX_BITS == 2) || (RADIX_BITS == 4) ||
        (RADIX_BITS == 8)) || ((WIDTH % RADIX_BITS) != 0)) begin : g_bad_radix
    arm_mul_iter_illegal_radix_bits u_illegal ();
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Sum of the shifted multiplicand for every set bit of one radix digit.
  function automatic logic signed [W2-1:0] pp_f(
    input logic signed [W2-1:0]      mc,
    input logic [RADIX_BITS-1:0]     dig
  );
    logic signed [W2-1:0] acc;
    acc = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (dig[i]) acc = acc + (mc <<< i);
    end
    return acc;
  endfunction

  // Control / output registers (reset)
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             long_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             wrd_hi_q;
  logic             n_q;
  logic             z_q;
  logic             c_q;
  logic             v_q;

  // Datapath registers (no reset: only meaningful between start and DONE)
  logic signed [W2-1:0] mcand_q;
  logic signed [W2-1:0] psum_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 fill_q;
  logic                 c_lat_q;
  logic                 v_lat_q;

  // Load values sampled with start
  logic signed [W2-1:0] mcand_ld_d;
  logic signed [W2-1:0] psum_ld_d;
  logic                 fill_ld_d;

  // Per-iteration next values
  logic signed [W2-1:0] pp_d;
  logic signed [W2-1:0] sum_d;
  logic signed [W2-1:0] mcand_d;
  logic signed [W2-1:0] final_d;
  logic [WIDTH-1:0]     mplier_d;
  logic                 last_d;
  logic                 start_ok;

  assign start_ok = (state_q == S_IDLE) && mul_if.start;

  always_comb begin
    // Only signed long ops sign-extend the multiplicand; short results are
    // taken mod 2^WIDTH so the extension of a does not matter there.
    mcand_ld_d = (mul_if.op[1] && mul_if.op[2])
                 ? {{WIDTH{mul_if.a[WIDTH-1]}}, mul_if.a}
                 : {{WIDTH{1'b0}}, mul_if.a};
    psum_ld_d = '0;
    if (mul_if.op[0]) begin
      psum_ld_d = mul_if.op[1] ? {mul_if.acc_hi, mul_if.acc_lo}
                               : {{WIDTH{1'b0}}, mul_if.acc_lo};
    end
    // Short ops treat b as signed: the low WIDTH bits of the product are the
    // same either way, and this lets a negative short multiplier terminate early.
    fill_ld_d = (mul_if.op[1] ? mul_if.op[2] : 1'b1) & mul_if.b[WIDTH-1];
  end

  always_comb begin
    pp_d     = pp_f(mcand_q, mplier_q[RADIX_BITS-1:0]);
    sum_d    = psum_q + pp_d;
    mcand_d  = mcand_q <<< RADIX_BITS;
    mplier_d = {{RADIX_BITS{fill_q}}, mplier_q[WIDTH-1:RADIX_BITS]};
    last_d   = (cnt_q == CW'(ITER - 1)) ||
               ((EARLY_TERM != 0) && (mplier_d == {WIDTH{fill_q}}));
    // The unretired multiplier tail is all fill bits. A tail of ones is
    // worth -1 * 2^(k*RADIX_BITS), i.e. subtract the already-shifted
    // multiplicand. This holds for full-length runs too (k*RADIX_BITS=WIDTH).
    final_d  = fill_q ? (sum_d - mcand_d) : sum_d;
  end

  // ---- stage boundary: operand capture / iteration registers ----
  always_ff @(posedge clk) begin
    if (start_ok) begin
      mcand_q  <= mcand_ld_d;
      psum_q   <= psum_ld_d;
      mplier_q <= mul_if.b;
      fill_q   <= fill_ld_d;
      c_lat_q  <= mul_if.c_in;
      v_lat_q  <= mul_if.v_in;
    end else if (state_q == S_CALC) begin
      mcand_q  <= mcand_d;
      psum_q   <= sum_d;
      mplier_q <= mplier_d;
    end
  end

  // ---- stage boundary: FSM and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      long_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      wrd_hi_q <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (mul_if.start) begin
            state_q <= S_CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            long_q  <= mul_if.op[1];
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            c_q     <= c_lat_q;
            v_q     <= v_lat_q;
            res_lo_q <= final_d[WIDTH-1:0];
            if (long_q) begin
              res_hi_q <= final_d[W2-1:WIDTH];
              wrd_hi_q <= 1'b1;
              n_q      <= final_d[W2-1];
              z_q      <= (final_d == '0);
            end else begin
              res_hi_q <= '0;
              wrd_hi_q <= 1'b0;
              n_q      <= final_d[WIDTH-1];
              z_q      <= (final_d[WIDTH-1:0] == '0);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mul_if.busy   = busy_q;
  assign mul_if.done   = done_q;
  assign mul_if.res_lo = res_lo_q;
  assign mul_if.res_hi = res_hi_q;
  assign mul_if.wrd_hi = wrd_hi_q;
  assign mul_if.out_n  = n_q;
  assign mul_if.out_z  = z_q;
  assign mul_if.out_c  = c_q;
  assign mul_if.out_v  = v_q;

endmodule

// File: tb/tb_arm_mul_iter.sv
// Bench for arm_mul_iter: dut0 has early termination, dut1 runs full length.
// Both see identical stimulus; a spec-level model predicts busy/done timing and
// results per cycle, and literal expectations pin the model on known vectors.
module tb_arm_mul_iter;
  localparam int W = 32;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arm_mul_iter_if #(.WIDTH(W)) if0 ();
  arm_mul_iter_if #(.WIDTH(W)) if1 ();

  arm_mul_iter #(.WIDTH(W), .RADIX_BITS(R), .EARLY_TERM(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mul_if(if0)
  );
  arm_mul_iter #(.WIDTH(W), .RADIX_BITS(R), .EARLY_TERM(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mul_if(if1)
  );

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic wrd, n, z, c, v;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic act  [2];
  int   e0   [2];
  int   nn   [2];
  res_t nres [2];
  res_t held [2];
  int   lat  [2];

  // Cycle count straight from the rules: m = 1 + index of the highest bit
  // differing from the fill reference, n = max(1, ceil(m/R)).
  function automatic int model_n(logic [2:0] op, logic [W-1:0] b, int et);
    int m;
    logic refb;
    if (et == 0) return W / R;
    refb = (op[1] && !op[2]) ? 1'b0 : b[W-1];
    m = 0;
    for (int i = 0; i < W; i++) if (b[i] != refb) m = i + 1;
    return (m == 0) ? 1 : (m + R - 1) / R;
  endfunction

  function automatic res_t model_res(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                     logic [W-1:0] ahi, logic [W-1:0] alo,
                                     logic c, logic v);
    res_t r;
    logic [63:0] acc, prod, s64;
    logic [31:0] s32;
    acc = op[0] ? (op[1] ? {ahi, alo} : {32'h0, alo}) : 64'h0;
    if (op[1]) begin
      if (op[2]) prod = longint'($signed(a)) * longint'($signed(b));
      else       prod = {32'h0, a} * {32'h0, b};
      s64   = prod + acc;
      r.lo  = s64[31:0];
      r.hi  = s64[63:32];
      r.wrd = 1'b1;
      r.n   = s64[63];
      r.z   = (s64 == 64'h0);
    end else begin
      s32   = a * b + acc[31:0];
      r.lo  = s32;
      r.hi  = '0;
      r.wrd = 1'b0;
      r.n   = s32[31];
      r.z   = (s32 == 32'h0);
    end
    r.c = c;
    r.v = v;
    return r;
  endfunction

  task automatic chk(string nm, int d, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, got, exp);
    end
  endtask

  function automatic res_t got_of(int d);
    res_t g;
    if (d == 0) g = '{if0.res_lo, if0.res_hi, if0.wrd_hi, if0.out_n, if0.out_z, if0.out_c, if0.out_v};
    else        g = '{if1.res_lo, if1.res_hi, if1.wrd_hi, if1.out_n, if1.out_z, if1.out_c, if1.out_v};
    return g;
  endfunction

  // Compare process: advance to the next falling edge, update the model for the
  // rising edge just passed (edge number cyc), then check both DUTs.
  task automatic tick();
    res_t g;
    logic eb, ed, gb, gd;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        act[d]  = 1'b0;
        held[d] = '0;
      end else begin
        if (if0.start && (!act[d] || cyc >= e0[d] + nn[d] + 2)) begin
          act[d]  = 1'b1;
          e0[d]   = cyc;
          nn[d]   = model_n(if0.op, if0.b, (d == 0) ? 1 : 0);
          nres[d] = model_res(if0.op, if0.a, if0.b, if0.acc_hi, if0.acc_lo, if0.c_in, if0.v_in);
        end
        if (act[d] && cyc == e0[d] + nn[d]) held[d] = nres[d];
      end
      eb = act[d] && (cyc >= e0[d]) && (cyc <= e0[d] + nn[d]);
      ed = act[d] && (cyc == e0[d] + nn[d]);
      gb = (d == 0) ? if0.busy : if1.busy;
      gd = (d == 0) ? if0.done : if1.done;
      g  = got_of(d);
      chk("busy", d, 64'(gb), 64'(eb));
      chk("done", d, 64'(gd), 64'(ed));
      chk("result", d, {g.hi, g.lo}, {held[d].hi, held[d].lo});
      chk("flags", d, 64'({g.wrd, g.n, g.z, g.c, g.v}),
          64'({held[d].wrd, held[d].n, held[d].z, held[d].c, held[d].v}));
    end
  endtask

  task automatic drive(logic s, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] ahi, logic [W-1:0] alo, logic c, logic v);
    if0.start = s; if0.op = op; if0.a = a; if0.b = b;
    if0.acc_hi = ahi; if0.acc_lo = alo; if0.c_in = c; if0.v_in = v;
    if1.start = s; if1.op = op; if1.a = a; if1.b = b;
    if1.acc_hi = ahi; if1.acc_lo = alo; if1.c_in = c; if1.v_in = v;
  endtask

  task automatic set_start(logic s);
    if0.start = s;
    if1.start = s;
  endtask

  // Issue one op and wait (bounded) for both done pulses; lat[] = cycles E0->done.
  // poke > 0 re-asserts start (with a different a) that many cycles into CALC.
  task automatic run_op(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] ahi, logic [W-1:0] alo, logic c, logic v, int poke);
    #1 drive(1'b1, op, a, b, ahi, alo, c, v);
    tick();
    #1 set_start(1'b0);
    lat[0] = 0;
    lat[1] = 0;
    for (int i = 1; i <= 40 && (lat[0] == 0 || lat[1] == 0); i++) begin
      tick();
      if (if0.done && lat[0] == 0) lat[0] = i;
      if (if1.done && lat[1] == 0) lat[1] = i;
      #1;
      if (i == poke) begin
        if0.a = ~a; if1.a = ~a;
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
    end
    chk("done_seen", 0, 64'(lat[0] != 0 && lat[1] != 0), 64'd1);
    tick();
  endtask

  initial begin
    act = '{1'b0, 1'b0};
    e0 = '{0, 0};
    nn = '{0, 0};
    held = '{res_t'(0), res_t'(0)};
    nres = held;
    drive(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 0, 64'(if0.busy), 64'd0);
    chk("rst_res", 0, {if0.res_hi, if0.res_lo}, 64'd0);
    #1 rst_n = 1'b1;
    tick();

    // MUL 7*6
    run_op(3'b000, 32'd7, 32'd6, '0, '0, 1'b0, 1'b0, 0);
    chk("mul_lat", 0, 64'(lat[0]), 64'd2);
    chk("mul_res", 0, {if0.res_hi, if0.res_lo}, 64'd42);
    chk("mul_flags", 0, 64'({if0.wrd_hi, if0.out_n, if0.out_z}), 64'd0);

    // UMULL 0xFFFFFFFF^2
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 1'b0, 1'b0, 0);
    chk("umull_lat", 0, 64'(lat[0]), 64'd16);
    chk("umull_res", 0, {if0.res_hi, if0.res_lo}, 64'hFFFF_FFFE_0000_0001);
    chk("umull_flags", 0, 64'({if0.wrd_hi, if0.out_n, if0.out_z}), 64'b110);

    // SMLAL -2*3 + 5
    run_op(3'b111, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'd5, 1'b0, 1'b0, 0);
    chk("smlal_lat", 0, 64'(lat[0]), 64'd1);
    chk("smlal_res", 0, {if0.res_hi, if0.res_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("smlal_n", 0, 64'(if0.out_n), 64'd1);

    // MUL by zero, C/V pass-through
    run_op(3'b000, 32'h1234, 32'h0, '0, '0, 1'b1, 1'b0, 0);
    chk("mul0_lat", 0, 64'(lat[0]), 64'd1);
    chk("mul0_flags", 0, 64'({if0.out_n, if0.out_z, if0.out_c, if0.out_v}), 64'b0110);

    // Start pulsed mid-CALC is ignored
    run_op(3'b010, 32'd1, 32'hFFFF_FFFF, '0, '0, 1'b0, 1'b1, 5);
    chk("poke_lat", 0, 64'(lat[0]), 64'd16);
    chk("poke_res", 0, {if0.res_hi, if0.res_lo}, 64'h0000_0000_FFFF_FFFF);

    // Negative short multiplier: early vs full length
    run_op(3'b000, 32'd5, 32'hFFFF_FFFF, '0, '0, 1'b0, 1'b0, 0);
    chk("neg_lat_et1", 0, 64'(lat[0]), 64'd1);
    chk("neg_lat_et0", 1, 64'(lat[1]), 64'd16);
    chk("neg_res_et1", 0, 64'(if0.res_lo), 64'hFFFF_FFFB);
    chk("neg_res_et0", 1, 64'(if1.res_lo), 64'hFFFF_FFFB);

    // Assorted patterns checked by the model
    run_op(3'b001, 32'hFFFF_FFFD, 32'd100, '0, 32'd7, 1'b1, 1'b1, 0);
    chk("mla_res", 0, 64'(if0.res_lo), 64'(32'hFFFF_FEDB));
    run_op(3'b110, 32'h8000_0000, 32'h7FFF_FFFF, '0, '0, 1'b0, 1'b0, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    chk("umlal_res", 0, {if0.res_hi, if0.res_lo}, 64'h0000_0003_FFFF_FFFD);
    run_op(3'b110, 32'd3, 32'h8000_0000, '0, '0, 1'b0, 1'b0, 0);
    run_op(3'b010, 32'd3, 32'h10, '0, '0, 1'b0, 1'b0, 0);
    chk("umull_b16_lat", 0, 64'(lat[0]), 64'd3);
    chk("umull_b16_res", 0, {if0.res_hi, if0.res_lo}, 64'h30);
    run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 1'b0, 1'b0, 0);
    run_op(3'b111, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'd1, 1'b0, 1'b0, 0);
    chk("smlal_zero", 0, 64'({if0.out_z, if0.wrd_hi}), 64'b11);

    // Reset mid-CALC aborts without a late done
    #1 drive(1'b1, 3'b010, 32'h1234_5678, 32'hFFFF_FFFF, '0, '0, 1'b1, 1'b1);
    tick();
    #1 set_start(1'b0);
    repeat (6) tick();
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("abort_busy", 0, 64'({if0.busy, if0.done}), 64'd0);
    chk("abort_res", 0, {if0.res_hi, if0.res_lo}, 64'd0);
    #1 rst_n = 1'b1;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
